// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types, encodings and helpers for the pipeline hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  // Record field widths; the hazard unit's REG_AW / T_W must not exceed these.
  localparam int PIPE_REG_AW = 5;
  localparam int PIPE_T_W    = 2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_E  = 2'd3;

  localparam logic [PIPE_T_W-1:0] TUSE_NONE = PIPE_T_W'(3);

  typedef struct packed {
    logic                   valid;
    logic [PIPE_REG_AW-1:0] rs;
    logic [PIPE_REG_AW-1:0] rt;
    logic [PIPE_REG_AW-1:0] a3;
    logic [PIPE_T_W-1:0]    tnew;
    logic                   wr;
  } stage_rec_t;

  localparam stage_rec_t REC_NONE = '0;

  function automatic logic [PIPE_T_W-1:0] sat_dec(input logic [PIPE_T_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  function automatic logic rec_match(input stage_rec_t r, input logic [PIPE_REG_AW-1:0] src);
    return r.valid && r.wr && (r.a3 != '0) && (r.a3 == src);
  endfunction

  function automatic logic rec_hazard(input stage_rec_t r,
                                      input logic [PIPE_REG_AW-1:0] src,
                                      input logic [PIPE_T_W-1:0] tuse);
    return (tuse != TUSE_NONE) && rec_match(r, src) && (tuse < r.tnew);
  endfunction

  // The nearest matching producer decides: it forwards when ready, otherwise
  // it shadows older (stale) copies and the select stays at FWD_RF.
  function automatic logic [1:0] fwd_pick(input stage_rec_t e,
                                          input stage_rec_t m,
                                          input stage_rec_t w,
                                          input logic [PIPE_REG_AW-1:0] src);
    if (rec_match(e, src)) return (e.tnew == '0) ? FWD_E : FWD_RF;
    if (rec_match(m, src)) return (m.tnew == '0) ? FWD_M : FWD_RF;
    if (rec_match(w, src)) return (w.tnew == '0) ? FWD_W : FWD_RF;
    return FWD_RF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_busy_ctr.sv
// ============================================================================
// Module      : md_busy_ctr
// Description : Mult/div busy counter; loads the unit latency on issue, counts to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_busy_ctr #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic div_i,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign busy_o = busy_q;

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module      : hazard_unit
// Description : Stall/bubble and forwarding control for the 5-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW      = PIPE_REG_AW,
  parameter int T_W         = PIPE_T_W,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [T_W-1:0]    tuse_rsD,
  input  logic [T_W-1:0]    tuse_rtD,
  input  logic [REG_AW-1:0] a3D,
  input  logic [T_W-1:0]    tnewD,
  input  logic              reg_writeD,
  input  logic              md_startD,
  input  logic              md_divD,
  input  logic              md_useD,
  output logic              stallD,
  output logic              flushE,
  output logic [1:0]        fwd_rsD,
  output logic [1:0]        fwd_rtD,
  output logic [1:0]        fwd_rsE,
  output logic [1:0]        fwd_rtE,
  output logic              fwd_rtM,
  output logic              md_busy
);

  stage_rec_t e_q, e_d, m_q, m_d, w_q, w_d;

  logic [PIPE_REG_AW-1:0] rs_src, rt_src;
  logic [PIPE_T_W-1:0]    tuse_rs, tuse_rt;
  logic                   data_stall;
  logic                   unused_rec_bits;

  assign rs_src  = PIPE_REG_AW'(rsD);
  assign rt_src  = PIPE_REG_AW'(rtD);
  assign tuse_rs = PIPE_T_W'(tuse_rsD);
  assign tuse_rt = PIPE_T_W'(tuse_rtD);

  // W results are always ready by the time a consumer could stall on them.
  always_comb begin
    data_stall = rec_hazard(e_q, rs_src, tuse_rs) | rec_hazard(e_q, rt_src, tuse_rt) |
                 rec_hazard(m_q, rs_src, tuse_rs) | rec_hazard(m_q, rt_src, tuse_rt);
    stallD  = data_stall | (md_useD & md_busy);
    flushE  = stallD;
    fwd_rsD = fwd_pick(e_q, m_q, w_q, rs_src);
    fwd_rtD = fwd_pick(e_q, m_q, w_q, rt_src);
    fwd_rsE = fwd_pick(REC_NONE, m_q, w_q, e_q.rs);
    fwd_rtE = fwd_pick(REC_NONE, m_q, w_q, e_q.rt);
    fwd_rtM = (fwd_pick(REC_NONE, REC_NONE, w_q, m_q.rt) == FWD_W);
  end

  always_comb begin
    w_d      = m_q;
    w_d.tnew = sat_dec(m_q.tnew);
    m_d      = e_q;
    m_d.tnew = sat_dec(e_q.tnew);
    e_d      = REC_NONE;
    if (!stallD) begin
      e_d.valid = 1'b1;
      e_d.rs    = rs_src;
      e_d.rt    = rt_src;
      e_d.a3    = PIPE_REG_AW'(a3D);
      e_d.tnew  = sat_dec(PIPE_T_W'(tnewD));
      e_d.wr    = reg_writeD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= REC_NONE;
      m_q <= REC_NONE;
      w_q <= REC_NONE;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // Source fields of the older records are carried along but never consulted.
  assign unused_rec_bits = ^{m_q.rs, w_q.rs, w_q.rt};

  md_busy_ctr #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_ctr (
    .clk    (clk),
    .reset  (reset),
    .load_i (md_startD & ~stallD),
    .div_i  (md_divD),
    .busy_o (md_busy)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
// Module      : tb_hazard_unit
// Description : Directed self-checking bench for hazard_unit with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rsD, rtD, a3D;
  logic [1:0] tuse_rsD, tuse_rtD, tnewD;
  logic       reg_writeD, md_startD, md_divD, md_useD;
  logic       stallD, flushE, fwd_rtM, md_busy;
  logic [1:0] fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk        (clk),
    .reset      (reset),
    .rsD        (rsD),
    .rtD        (rtD),
    .tuse_rsD   (tuse_rsD),
    .tuse_rtD   (tuse_rtD),
    .a3D        (a3D),
    .tnewD      (tnewD),
    .reg_writeD (reg_writeD),
    .md_startD  (md_startD),
    .md_divD    (md_divD),
    .md_useD    (md_useD),
    .stallD     (stallD),
    .flushE     (flushE),
    .fwd_rsD    (fwd_rsD),
    .fwd_rtD    (fwd_rtD),
    .fwd_rsE    (fwd_rsE),
    .fwd_rtE    (fwd_rtE),
    .fwd_rtM    (fwd_rtM),
    .md_busy    (md_busy)
  );

  // Model: instructions that left D, tagged with the cycle they left it.
  // Age = cycles since then (1=E, 2=M, 3=W); result exists from cycle t+tnew.
  typedef struct {
    int t;
    int tnew;
    int a3;
    bit wr;
    int rs;
    int rt;
  } instr_t;

  instr_t fl[$];
  int     cyc     = 0;
  int     md_last = -1;

  function automatic int left_of(input instr_t p);
    int l;
    l = p.t + p.tnew - cyc;
    return (l < 0) ? 0 : l;
  endfunction

  function automatic bit hits(input instr_t p, input int src);
    return p.wr && (p.a3 != 0) && (p.a3 == src);
  endfunction

  function automatic int fwd_code(input int src, input int min_age);
    for (int age = min_age; age <= 3; age++)
      foreach (fl[i])
        if ((cyc - fl[i].t) == age && hits(fl[i], src))
          return (left_of(fl[i]) == 0) ? (4 - age) : 0;
    return 0;
  endfunction

  function automatic bit at_age(input int age, output instr_t p);
    foreach (fl[i])
      if ((cyc - fl[i].t) == age) begin
        p = fl[i];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    bit s;
    int age;
    s = 1'b0;
    foreach (fl[i]) begin
      age = cyc - fl[i].t;
      if (age == 1 || age == 2) begin
        if (hits(fl[i], int'(rsD)) && tuse_rsD != 2'd3 && int'(tuse_rsD) < left_of(fl[i])) s = 1'b1;
        if (hits(fl[i], int'(rtD)) && tuse_rtD != 2'd3 && int'(tuse_rtD) < left_of(fl[i])) s = 1'b1;
      end
    end
    if (md_useD && cyc <= md_last) s = 1'b1;
    return s;
  endfunction

  function automatic void model_step();
    instr_t n;
    if (reset) begin
      fl.delete();
      md_last = -1;
    end else if (!m_stall()) begin
      n.t = cyc; n.tnew = int'(tnewD); n.a3 = int'(a3D);
      n.wr = reg_writeD; n.rs = int'(rsD); n.rt = int'(rtD);
      fl.push_back(n);
      if (md_startD) md_last = cyc + (md_divD ? 10 : 5);
    end
    cyc++;
    while (fl.size() > 0 && (cyc - fl[0].t) > 3) void'(fl.pop_front());
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en && !reset) begin
      instr_t pe, pm;
      bit     s, has_e, has_m;
      s     = m_stall();
      has_e = at_age(1, pe);
      has_m = at_age(2, pm);
      chk("stallD",  stallD, 4'(s));
      chk("flushE",  flushE, 4'(s));
      chk("fwd_rsD", fwd_rsD, 4'(fwd_code(int'(rsD), 1)));
      chk("fwd_rtD", fwd_rtD, 4'(fwd_code(int'(rtD), 1)));
      chk("fwd_rsE", fwd_rsE, has_e ? 4'(fwd_code(pe.rs, 2)) : 4'd0);
      chk("fwd_rtE", fwd_rtE, has_e ? 4'(fwd_code(pe.rt, 2)) : 4'd0);
      chk("fwd_rtM", fwd_rtM, has_m ? 4'(fwd_code(pm.rt, 3)) : 4'd0);
      chk("md_busy", md_busy, 4'(cyc <= md_last));
    end
  end

  task automatic drv(input int rs, input int tus, input int rt, input int tut,
                     input int a3, input int tn, input bit wr,
                     input bit mds, input bit mdd, input bit mdu);
    rsD = 5'(rs); tuse_rsD = 2'(tus); rtD = 5'(rt); tuse_rtD = 2'(tut);
    a3D = 5'(a3); tnewD = 2'(tn); reg_writeD = wr;
    md_startD = mds; md_divD = mdd; md_useD = mdu;
  endtask

  task automatic nop();
    drv(0, 3, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    nop();
    tick();
    tick();
    reset = 1'b0;
    cmp_en = 1'b1;
    #2;
    chk("lit_rst_stall", stallD, 4'd0);
    chk("lit_rst_flush", flushE, 4'd0);
    chk("lit_rst_fwdD",  {fwd_rsD, fwd_rtD}, 4'd0);
    chk("lit_rst_fwdE",  {fwd_rsE, fwd_rtE}, 4'd0);
    chk("lit_rst_fwdM",  fwd_rtM, 4'd0);
    chk("lit_rst_busy",  md_busy, 4'd0);
    tick();

    // lw $1,0($2) ; add $2,$1,$3
    drv(2, 1, 0, 3, 1, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1, 1, 3, 1, 2, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    #2; chk("lit_lw_stall", stallD, 4'd1);
    chk("lit_lw_flush", flushE, 4'd1);
    tick();
    #2; chk("lit_lw_release", stallD, 4'd0);
    tick();
    #2; chk("lit_lw_fwd_rsE", fwd_rsE, 4'd1);
    chk("lit_lw_fwd_rtE", fwd_rtE, 4'd0);
    drain();

    // add $1,$4,$5 ; beq $1,$1
    drv(4, 1, 5, 1, 1, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1, 0, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2; chk("lit_beq_stall", stallD, 4'd1);
    tick();
    #2; chk("lit_beq_release", stallD, 4'd0);
    chk("lit_beq_fwd_rsD", fwd_rsD, 4'd2);
    chk("lit_beq_fwd_rtD", fwd_rtD, 4'd2);
    tick();
    drain();

    // add $0,... ; add $2,$0,$0
    drv(4, 1, 5, 1, 0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drv(0, 1, 0, 1, 2, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    #2; chk("lit_r0_stall", stallD, 4'd0);
    chk("lit_r0_fwdD", {fwd_rsD, fwd_rtD}, 4'd0);
    tick();
    #2; chk("lit_r0_fwdE", {fwd_rsE, fwd_rtE}, 4'd0);
    drain();

    // add $1 (tnew 1) ; ori $1 (tnew 1) ; reader of $1
    drv(4, 1, 5, 1, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drv(6, 1, 0, 3, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1, 0, 1, 1, 7, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    #2; chk("lit_ewins_stall", stallD, 4'd0);
    chk("lit_ewins_fwd_rsD", fwd_rsD, 4'd3);
    chk("lit_ewins_fwd_rtD", fwd_rtD, 4'd3);
    tick();
    #2; chk("lit_mwins_fwd_rsE", fwd_rsE, 4'd2);
    drain();

    // mult $8,$9 ; mfhi $10
    drv(8, 1, 9, 1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    drv(0, 3, 0, 3, 10, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #2; chk("lit_mult_busy", md_busy, 4'd1);
      chk("lit_mult_stall", stallD, 4'd1);
      tick();
    end
    #2; chk("lit_mult_done_busy", md_busy, 4'd0);
    chk("lit_mult_done_stall", stallD, 4'd0);
    tick();
    drain();

    // div, then reset while the counter sits at 7 and a load-use stall is pending
    drv(8, 1, 9, 1, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    nop();
    tick();
    tick();
    drv(2, 1, 0, 3, 3, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drv(3, 0, 0, 3, 4, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    #2; chk("lit_div_stall", stallD, 4'd1);
    chk("lit_div_busy", md_busy, 4'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2; chk("lit_rst2_stall", stallD, 4'd0);
    chk("lit_rst2_busy", md_busy, 4'd0);
    chk("lit_rst2_fwdD", {fwd_rsD, fwd_rtD}, 4'd0);
    tick();
    #2; chk("lit_rst2_fwd_rsE", fwd_rsE, 4'd0);
    chk("lit_rst2_busy_after", md_busy, 4'd0);
    drain();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
